// File: rtl/tag_tx_bits_loader.sv
// Packs an MSB-first byte stream into a shadow frame and swaps it into tx_bits at controller frame boundaries.
// Optional TAG_TX_BITS_REPEAT_EN: on underrun, repeat the last frame instead of driving IDLE_PATTERN.
module tag_tx_bits_loader #(
  parameter int                       TX_BITS_WIDTH = 128,
  parameter int                       BIT_CNT_WIDTH = 7,
  parameter logic [TX_BITS_WIDTH-1:0] IDLE_PATTERN  = '0,
  parameter int                       CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               s_tdata,
  input  logic                     s_tvalid,
  input  logic                     s_tlast,
  output logic                     s_tready,
  input  logic [BIT_CNT_WIDTH-1:0] ntx_bits_cnt,
  output logic [TX_BITS_WIDTH-1:0] tx_bits,
  output logic                     frame_active,
  output logic                     underrun,
  output logic [CNT_WIDTH-1:0]     frames_sent,
  output logic [CNT_WIDTH-1:0]     underrun_cnt
);

  localparam int NBYTES = TX_BITS_WIDTH / 8;
  localparam int IDX_W  = $clog2(NBYTES) + 1;

  typedef enum logic {FILL, FULL} state_t;

  state_t                   state, state_nxt;
  logic [IDX_W-1:0]         byte_idx;
  logic [TX_BITS_WIDTH-1:0] shadow, shadow_wr;
  logic [BIT_CNT_WIDTH-1:0] prev_cnt;
  logic                     accept, completing, boundary, frame_ready;

  assign s_tready = (state == FILL);

  always_comb begin
    accept      = s_tvalid && (state == FILL);
    completing  = accept && (s_tlast || (byte_idx == IDX_W'(NBYTES - 1)));
    boundary    = (prev_cnt == '1) && (ntx_bits_cnt == '0);
    // A byte that completes the frame on the boundary cycle makes it swappable now.
    frame_ready = (state == FULL) || completing;
    shadow_wr   = shadow;
    for (int i = 0; i < NBYTES; i++) begin
      if (accept && (byte_idx == IDX_W'(i))) begin
        shadow_wr[TX_BITS_WIDTH-1-8*i -: 8] = s_tdata;
      end
    end
    state_nxt = state;
    if (boundary && frame_ready) begin
      state_nxt = FILL;
    end else if (completing) begin
      state_nxt = FULL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_bits      <= IDLE_PATTERN;
      frame_active <= 1'b0;
      underrun     <= 1'b0;
      frames_sent  <= '0;
      underrun_cnt <= '0;
      shadow       <= '0;
      byte_idx     <= '0;
      prev_cnt     <= '1;
    end else begin
      prev_cnt <= ntx_bits_cnt;
      underrun <= 1'b0;
      if (boundary && frame_ready) begin
        tx_bits      <= shadow_wr;
        frame_active <= 1'b1;
        frames_sent  <= frames_sent + CNT_WIDTH'(1);
        shadow       <= '0;
        byte_idx     <= '0;
      end else begin
        if (accept) begin
          shadow   <= shadow_wr;
          byte_idx <= byte_idx + IDX_W'(1);
        end
        if (boundary) begin
          underrun <= 1'b1;
          if (underrun_cnt != '1) begin
            underrun_cnt <= underrun_cnt + CNT_WIDTH'(1);
          end
`ifdef TAG_TX_BITS_REPEAT_EN
          // Controller keeps shifting the previous frame.
`else
          tx_bits      <= IDLE_PATTERN;
          frame_active <= 1'b0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_tag_tx_bits_loader.sv
// Directed test of tag_tx_bits_loader: framing, zero pad, underrun, same-cycle swap, overflow into next frame, reset.
module tb_tag_tx_bits_loader;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   s_tdata;
  logic         s_tvalid;
  logic         s_tlast;
  logic         s_tready;
  logic [6:0]   ntx_bits_cnt;
  logic [127:0] tx_bits;
  logic         frame_active;
  logic         underrun;
  logic [15:0]  frames_sent;
  logic [15:0]  underrun_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  tag_tx_bits_loader dut (
    .clk          (clk),
    .reset        (reset),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tlast      (s_tlast),
    .s_tready     (s_tready),
    .ntx_bits_cnt (ntx_bits_cnt),
    .tx_bits      (tx_bits),
    .frame_active (frame_active),
    .underrun     (underrun),
    .frames_sent  (frames_sent),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    s_tvalid     = 1'b0;
    s_tlast      = 1'b0;
    s_tdata      = 8'h00;
    ntx_bits_cnt = 7'd1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    logic rdy_seen;
    rdy_seen = 1'b0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      rdy_seen = s_tready;
      step();
      if (rdy_seen) break;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (!rdy_seen) chk("push_timeout", {127'd0, rdy_seen}, 128'd1);
  endtask

  // Short wrap: 127 -> 0, leaving the counter parked at 1 after the swap edge.
  task automatic wrap();
    ntx_bits_cnt = 7'd127;
    step();
    ntx_bits_cnt = 7'd0;
    step();
    ntx_bits_cnt = 7'd1;
  endtask

  logic [127:0] held;

  initial begin
    do_reset();
    chk("rst_tx_bits",  tx_bits, 128'h0);
    chk("rst_active",   {127'd0, frame_active}, 128'd0);
    chk("rst_underrun", {127'd0, underrun}, 128'd0);
    chk("rst_frames",   {112'd0, frames_sent}, 128'd0);
    chk("rst_ucnt",     {112'd0, underrun_cnt}, 128'd0);
    chk("rst_tready",   {127'd0, s_tready}, 128'd1);

    // Full 16-byte frame, then a full counter sweep to the wrap.
    push(8'h0A, 1'b0);
    for (int i = 1; i < 16; i++) push(8'hAA, i == 15);
    chk("t1_full_tready", {127'd0, s_tready}, 128'd0);
    for (int c = 2; c < 128; c++) begin
      ntx_bits_cnt = 7'(c);
      step();
    end
    ntx_bits_cnt = 7'd0;
    step();
    ntx_bits_cnt = 7'd1;
    chk("t1_tx_bits", tx_bits, 128'h0AAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA);
    chk("t1_active",  {127'd0, frame_active}, 128'd1);
    chk("t1_frames",  {112'd0, frames_sent}, 128'd1);
    chk("t1_tready",  {127'd0, s_tready}, 128'd1);
    chk("t1_underrun", {127'd0, underrun}, 128'd0);

    // Counter held: no boundaries, output stable.
    for (int i = 0; i < 20; i++) step();
    chk("hold_tx_bits", tx_bits, 128'h0AAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA);
    chk("hold_ucnt",    {112'd0, underrun_cnt}, 128'd0);

    // Short frame, zero padded.
    for (int i = 0; i < 10; i++) push(8'hAA, i == 9);
    wrap();
    chk("t2_tx_bits", tx_bits, 128'hAAAA_AAAA_AAAA_AAAA_AAAA_0000_0000_0000);
    chk("t2_frames",  {112'd0, frames_sent}, 128'd2);

    // Three underruns with no input.
    for (int k = 0; k < 3; k++) begin
      wrap();
      chk("t3_pulse_hi", {127'd0, underrun}, 128'd1);
      step();
      chk("t3_pulse_lo", {127'd0, underrun}, 128'd0);
    end
    chk("t3_ucnt", {112'd0, underrun_cnt}, 128'd3);
`ifdef TAG_TX_BITS_REPEAT_EN
    chk("t3_tx_bits", tx_bits, 128'hAAAA_AAAA_AAAA_AAAA_AAAA_0000_0000_0000);
    chk("t3_active",  {127'd0, frame_active}, 128'd1);
`else
    chk("t3_tx_bits", tx_bits, 128'h0);
    chk("t3_active",  {127'd0, frame_active}, 128'd0);
`endif
    chk("t3_frames", {112'd0, frames_sent}, 128'd2);

    // Final byte accepted on the boundary cycle.
    for (int i = 1; i < 16; i++) push(8'(i), 1'b0);
    ntx_bits_cnt = 7'd127;
    step();
    ntx_bits_cnt = 7'd0;
    s_tdata      = 8'h10;
    s_tlast      = 1'b0;
    s_tvalid     = 1'b1;
    step();
    s_tvalid     = 1'b0;
    ntx_bits_cnt = 7'd1;
    chk("t4_tx_bits", tx_bits, 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10);
    chk("t4_underrun", {127'd0, underrun}, 128'd0);
    chk("t4_frames",  {112'd0, frames_sent}, 128'd3);
    chk("t4_ucnt",    {112'd0, underrun_cnt}, 128'd3);
    chk("t4_active",  {127'd0, frame_active}, 128'd1);

    // 20 bytes without tlast: 16 fill frame 1, the rest start frame 2.
    for (int i = 0; i < 16; i++) push(8'(8'h11 + i), 1'b0);
    step();
    chk("t5_stall", {127'd0, s_tready}, 128'd0);
    wrap();
    chk("t5_f1_tx_bits", tx_bits, 128'h1112_1314_1516_1718_191A_1B1C_1D1E_1F20);
    chk("t5_tready",     {127'd0, s_tready}, 128'd1);
    for (int i = 16; i < 20; i++) push(8'(8'h11 + i), i == 19);
    wrap();
    chk("t5_f2_tx_bits", tx_bits, 128'h2122_2324_0000_0000_0000_0000_0000_0000);
    chk("t5_frames",     {112'd0, frames_sent}, 128'd5);

    // Reset mid-fill discards the partial frame.
    for (int i = 0; i < 5; i++) push(8'hFF, 1'b0);
    do_reset();
    chk("t6_rst_tx_bits", tx_bits, 128'h0);
    chk("t6_rst_frames",  {112'd0, frames_sent}, 128'd0);
    chk("t6_rst_ucnt",    {112'd0, underrun_cnt}, 128'd0);
    for (int i = 0; i < 16; i++) push(8'(8'h30 + i), i == 15);
    wrap();
    held = tx_bits;
    chk("t6_tx_bits", held, 128'h3031_3233_3435_3637_3839_3A3B_3C3D_3E3F);
    chk("t6_frames",  {112'd0, frames_sent}, 128'd1);
    chk("t6_ucnt",    {112'd0, underrun_cnt}, 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tag_tx_bits_loader.md
Name: tag_tx_bits_loader

Overview:
Upstream feeder for the tag-chip MTX controller. Accepts a byte stream (valid/ready, last-delimited) and packs it MSB-first into a TX_BITS_WIDTH shadow frame. At each controller frame boundary it double-buffers the shadow frame into the tx_bits word the controller is shifting out, and tracks underruns. Sits between the host/settings-side byte FIFO and the controller's tx_bits/ntx_bits_cnt interface.

Parameters:
TX_BITS_WIDTH, 128, frame width in bits; multiple of 8.
BIT_CNT_WIDTH, 7, width of controller bit counter; 2**BIT_CNT_WIDTH == TX_BITS_WIDTH.
IDLE_PATTERN, 128'h0, word driven on tx_bits when no frame is ready.
CNT_WIDTH, 16, width of frames_sent / underrun_cnt.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
s_tdata  in  8  input byte
s_tvalid  in  1  byte valid
s_tlast  in  1  last byte of frame
s_tready  out  1  loader can accept byte
ntx_bits_cnt  in  BIT_CNT_WIDTH  controller's current bit index
tx_bits  out  TX_BITS_WIDTH  active frame to controller
frame_active  out  1  tx_bits holds a real frame (not idle)
underrun  out  1  one-cycle pulse: boundary with no frame ready
frames_sent  out  CNT_WIDTH  frames swapped into tx_bits, wraps
underrun_cnt  out  CNT_WIDTH  underrun events, saturates at all-ones

Behaviour:
- Interface: one clock, clk; reset is synchronous, active-high, named reset.
- Reset values: tx_bits=IDLE_PATTERN, frame_active=0, underrun=0, frames_sent=0, underrun_cnt=0, s_tready=1; shadow=0, byte index=0, state FILL, prev_cnt=all-ones.
- Fill FSM, states FILL and FULL. s_tready = (state==FILL); combinational from state only.
- FILL: on s_tvalid&&s_tready, byte k (k=0 first) written to shadow[TX_BITS_WIDTH-1-8k -: 8]; k++.
- Go to FULL when s_tlast accepted or k reaches TX_BITS_WIDTH/8. Unwritten bytes stay 0 (zero pad). No tlast after the final byte = implicit end; the next byte starts the next frame.
- FULL: holds shadow, accepts nothing until swap.
- Boundary: registered prev_cnt; boundary = (prev_cnt == all-ones) && (ntx_bits_cnt == 0). Detected one cycle after the controller wraps; tx_bits updates on the following edge (total 1 cycle after wrap seen).
- On boundary with FULL: tx_bits<=shadow, frame_active<=1, frames_sent++, shadow<=0, k<=0, state<=FILL.
- Same-cycle: boundary while the completing byte (tlast or final byte) is accepted counts as FULL. The assembled word including that byte is swapped; no underrun.
- On boundary with FILL (not completing): tx_bits<=IDLE_PATTERN, frame_active<=0, underrun pulse 1 cycle, underrun_cnt++ (saturating). Partial shadow kept; filling continues.
- ntx_bits_cnt held constant: no boundaries, tx_bits stable indefinitely.
- Reset mid-fill or mid-frame: partial frame discarded, all state to reset values on next edge.

Optional Feature:
TAG_TX_BITS_REPEAT_EN: when defined, underrun keeps the previous tx_bits and leaves frame_active unchanged (repeat last frame); underrun pulse/count still asserted. When undefined, underrun loads IDLE_PATTERN and clears frame_active as above.

Test Plan:
- Reset then 16 bytes 0x0A,0xAA..0xAA with tlast on byte 16, drive ntx_bits_cnt 0..127 wrap -> tx_bits=128'h0AAA..AA one cycle after wrap seen, frame_active=1, frames_sent=1, s_tready=1 again.
- 10 bytes 0xAA, tlast on 10th -> after boundary tx_bits=80'hAAAA_AAAA_AAAA_AAAA_AAAA in bits[127:48], bits[47:0]=0.
- No input, 3 wraps -> 3 one-cycle underrun pulses, underrun_cnt=3, tx_bits=IDLE_PATTERN, frame_active=0. With TAG_TX_BITS_REPEAT_EN after a valid frame: tx_bits unchanged, frame_active=1.
- Final byte accepted in the same cycle as the boundary -> frame swapped, no underrun, frames_sent increments.
- 20 bytes, no tlast -> first 16 form frame 1, s_tready=0 until boundary, bytes 17-20 land in frame 2's top 32 bits.
- Assert reset after 5 bytes accepted, release, send full 16-byte frame -> tx_bits equals only the new frame; counters restart at 0.
